poly_store_fsm: RTL and testbench
=================================

POLY_STORE_FSM -- requirements
Module: poly_store_fsm

Interface
REQ-001 SHALL have parameter: COEF_W, 16, coefficient/FIFO word width.
REQ-002 SHALL have port: clk  input  1  clock, rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start_sto  input  1  one-cycle request to execute a store command.
REQ-005 SHALL have port: slot  input  3  target polynomial slot (command arg1).
REQ-006 SHALL have port: degree  input  5  polynomial degree N (command arg2).
REQ-007 SHALL have port: clear_all  input  1  invalidate all slots.
REQ-008 SHALL have port: fifo_empty  input  1  data FIFO empty flag.
REQ-009 SHALL have port: fifo_data  input  COEF_W  FIFO read data, valid the cycle after fifo_rd_en.
REQ-010 SHALL have port: fifo_rd_en  output  1  one-cycle FIFO pop strobe.
REQ-011 SHALL have port: rd_slot  input  3  read-port slot select.
REQ-012 SHALL have port: rd_idx  input  4  read-port coefficient index.
REQ-013 SHALL have port: rd_coef  output  COEF_W  coefficient at rd_slot/rd_idx.
REQ-014 SHALL have port: rd_degree  output  5  stored degree of rd_slot.
REQ-015 SHALL have port: rd_valid  output  1  rd_slot holds a complete polynomial.
REQ-016 SHALL have port: busy  output  1  store in progress.
REQ-017 SHALL have port: done_sto  output  1  one-cycle store-complete pulse.

Function
REQ-018 SHALL use states IDLE, READ, CAPT, DONE.
REQ-019 IDLE: on start_sto (clear_all low) SHALL latch slot, min(degree,10) as N, clear counter cnt, clear valid[slot], go READ.
REQ-020 READ: if fifo_empty low SHALL assert fifo_rd_en for exactly one cycle and go CAPT; else hold READ with fifo_rd_en low (indefinite stall).
REQ-021 CAPT: SHALL write fifo_data to coef[slot][cnt]; if cnt==N go DONE, else cnt+1 and go READ.
REQ-022 DONE: SHALL pulse done_sto one cycle, set valid[slot]=1, degree[slot]=N, go IDLE.
REQ-023 Minimum store latency SHALL be 2*(N+1)+2 cycles from start_sto to done_sto with FIFO never empty.
REQ-024 busy SHALL be high in READ, CAPT, DONE; start_sto while busy SHALL be ignored.
REQ-025 degree>10 SHALL be clamped to 10 (11 coefficients).
REQ-026 clear_all SHALL, in any state, clear all valid bits and degrees, abort any store (no done_sto, no further pops), return to IDLE next cycle; clear_all wins over simultaneous start_sto.
REQ-027 Read port SHALL be combinational; rd_idx>10 SHALL return rd_coef=0; indices above stored degree return last written value.
REQ-028 Storage SHALL be 8 slots x 11 coefficients x COEF_W; restoring a slot overwrites it.

Reset
REQ-029 rst low SHALL force IDLE, fifo_rd_en=0, done_sto=0, busy=0, all valid=0, all degrees=0, all coefficients=0.
REQ-030 Reset mid-store SHALL discard partial data; slot remains invalid.

Configuration
REQ-031 Macro POLY_STORE_COUNT_EN defined SHALL add output sto_count (16 bits, reset 0) incrementing on each done_sto, wrapping 0xFFFF->0, cleared by clear_all.
REQ-032 Without POLY_STORE_COUNT_EN the sto_count port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-033 start_sto slot=2 degree=3, FIFO holds 5,6,7,8 -> 4 pops, done_sto at cycle 10, rd_slot=2 gives 5,6,7,8, rd_degree=3, rd_valid=1.
REQ-034 Store slot=0 degree=1 with FIFO empty 5 cycles before each word -> fifo_rd_en only when non-empty, done_sto once, coefs correct.
REQ-035 degree=15 slot=7 -> exactly 11 pops, rd_degree=10, rd_idx=12 gives 0.
REQ-036 clear_all asserted in CAPT of 2nd word -> no done_sto, no further pops, rd_valid=0 all slots; start_sto+clear_all same cycle -> no store.
REQ-037 rst low during READ -> fifo_rd_en=0, busy=0 immediately, rd_valid=0; with POLY_STORE_COUNT_EN, 3 stores -> sto_count=3, clear_all -> 0.

Source files
------------

// File: rtl/poly_store_fsm.sv
// Polynomial store engine: pops up to 11 coefficients from a FIFO into one of 8 slots.
// Optional store counter output enabled by defining POLY_STORE_COUNT_EN.
module poly_store_fsm #(
    parameter int COEF_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_sto,
    input  logic [2:0]        slot,
    input  logic [4:0]        degree,
    input  logic              clear_all,
    input  logic              fifo_empty,
    input  logic [COEF_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    input  logic [2:0]        rd_slot,
    input  logic [3:0]        rd_idx,
    output logic [COEF_W-1:0] rd_coef,
    output logic [4:0]        rd_degree,
    output logic              rd_valid,
    output logic              busy,
    output logic              done_sto
`ifdef POLY_STORE_COUNT_EN
    ,
    output logic [15:0]       sto_count
`endif
);

    localparam int NCOEF = 11;
    localparam logic [3:0] MAX_N = 4'd10;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        CAPT,
        DONE
    } state_t;

    state_t state_q, state_d;
    logic [2:0] slot_q, slot_d;
    logic [3:0] n_q, n_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] valid_q, valid_d;
    logic       done_q, done_d;
    logic [3:0] deg_q [8];
    logic [3:0] deg_d [8];
    logic [COEF_W-1:0] coef_q [8][NCOEF];
    logic [COEF_W-1:0] coef_d [8][NCOEF];

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        n_d        = n_q;
        cnt_d      = cnt_q;
        valid_d    = valid_q;
        deg_d      = deg_q;
        coef_d     = coef_q;
        done_d     = 1'b0;
        fifo_rd_en = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_sto) begin
                    slot_d        = slot;
                    n_d           = (degree > 5'd10) ? MAX_N : degree[3:0];
                    cnt_d         = 4'd0;
                    valid_d[slot] = 1'b0;
                    state_d       = READ;
                end
            end
            READ: begin
                if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    state_d    = CAPT;
                end
            end
            CAPT: begin
                coef_d[slot_q][cnt_q] = fifo_data;
                if (cnt_q == n_q) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                    state_d = READ;
                end
            end
            DONE: begin
                done_d          = 1'b1;
                valid_d[slot_q] = 1'b1;
                deg_d[slot_q]   = n_q;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides everything, including a start in the same cycle.
        if (clear_all) begin
            state_d    = IDLE;
            valid_d    = '0;
            done_d     = 1'b0;
            fifo_rd_en = 1'b0;
            coef_d     = coef_q;
            for (int s = 0; s < 8; s++) begin
                deg_d[s] = 4'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            slot_q  <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            valid_q <= '0;
            done_q  <= 1'b0;
            for (int s = 0; s < 8; s++) begin
                deg_q[s] <= '0;
                for (int i = 0; i < NCOEF; i++) begin
                    coef_q[s][i] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            deg_q   <= deg_d;
            coef_q  <= coef_d;
        end
    end

`ifdef POLY_STORE_COUNT_EN
    logic [15:0] sto_count_q, sto_count_d;

    always_comb begin
        sto_count_d = sto_count_q + {15'd0, done_d};
        if (clear_all) begin
            sto_count_d = 16'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sto_count_q <= 16'd0;
        end else begin
            sto_count_q <= sto_count_d;
        end
    end

    assign sto_count = sto_count_q;
`endif

    always_comb begin
        rd_coef = '0;
        if (rd_idx <= MAX_N) begin
            rd_coef = coef_q[rd_slot][rd_idx];
        end
    end

    assign rd_degree = {1'b0, deg_q[rd_slot]};
    assign rd_valid  = valid_q[rd_slot];
    assign busy      = (state_q != IDLE);
    assign done_sto  = done_q;

endmodule

// File: tb/tb_poly_store_fsm.sv
// Bench for poly_store_fsm: vector table, corner sequences and random stores
// checked against a slot-array model fed by a behavioural FIFO.
module tb_poly_store_fsm;

    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         start_sto = 1'b0;
    logic [2:0]   slot = '0;
    logic [4:0]   degree = '0;
    logic         clear_all = 1'b0;
    logic         fifo_empty;
    logic [W-1:0] fifo_data = '0;
    logic         fifo_rd_en;
    logic [2:0]   rd_slot = '0;
    logic [3:0]   rd_idx = '0;
    logic [W-1:0] rd_coef;
    logic [4:0]   rd_degree;
    logic         rd_valid;
    logic         busy;
    logic         done_sto;
`ifdef POLY_STORE_COUNT_EN
    logic [15:0]  sto_count;
`endif

    poly_store_fsm #(.COEF_W(W)) dut (
        .clk(clk),
        .rst(rst),
        .start_sto(start_sto),
        .slot(slot),
        .degree(degree),
        .clear_all(clear_all),
        .fifo_empty(fifo_empty),
        .fifo_data(fifo_data),
        .fifo_rd_en(fifo_rd_en),
        .rd_slot(rd_slot),
        .rd_idx(rd_idx),
        .rd_coef(rd_coef),
        .rd_degree(rd_degree),
        .rd_valid(rd_valid),
        .busy(busy),
        .done_sto(done_sto)
`ifdef POLY_STORE_COUNT_EN
        ,
        .sto_count(sto_count)
`endif
    );

    // Behavioural FIFO: data appears the cycle after a pop.
    logic [W-1:0] fmem [1024];
    int  wptr = 0;
    int  rptr = 0;
    int  pops = 0;
    int  bad_pops = 0;
    int  dones = 0;
    int  gap_cnt = 100;
    bit  gap_mode = 1'b0;

    assign fifo_empty = (rptr == wptr) || (gap_mode && gap_cnt < 5);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_data <= fmem[rptr % 1024];
            rptr      <= rptr + 1;
            pops      <= pops + 1;
            if (fifo_empty) bad_pops <= bad_pops + 1;
        end
        if (done_sto) dones <= dones + 1;
        if (start_sto || fifo_rd_en) gap_cnt <= 0;
        else if (gap_cnt < 100) gap_cnt <= gap_cnt + 1;
    end

    // Reference model of the slot storage
    logic [W-1:0] m_coef [8][11];
    bit           m_known [8][11];
    int           m_deg [8];
    bit           m_valid [8];

    int errors = 0;
    int checks = 0;

    typedef struct {
        int s;
        int d;
        int exp_n;
        int exp_lat;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 8; s++) begin
            m_deg[s]   = 0;
            m_valid[s] = 1'b0;
            for (int i = 0; i < 11; i++) begin
                m_coef[s][i]  = '0;
                m_known[s][i] = 1'b1;
            end
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < 8; s++) begin
            m_deg[s]   = 0;
            m_valid[s] = 1'b0;
        end
    endtask

    task automatic push(input logic [W-1:0] v);
        fmem[wptr % 1024] = v;
        wptr++;
    endtask

    task automatic check_slots();
        for (int s = 0; s < 8; s++) begin
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                rd_slot = s[2:0];
                rd_idx  = i[3:0];
                #1;
                if (i > 10) chk($sformatf("coef_hi s%0d i%0d", s, i), rd_coef, 0);
                else if (m_known[s][i])
                    chk($sformatf("coef s%0d i%0d", s, i), rd_coef, m_coef[s][i]);
                if (i == 0) begin
                    chk($sformatf("deg s%0d", s), rd_degree, m_deg[s]);
                    chk($sformatf("valid s%0d", s), rd_valid, m_valid[s]);
                end
            end
        end
    endtask

    // Pushes 16 words, runs one store, updates the model from the spec rules.
    task automatic store(input int s, input int d, input int base,
                         output int lat, output int npop);
        int n;
        int p0;
        int dn0;
        bit ok;
        logic [W-1:0] w [16];
        n = (d > 10) ? 10 : d;
        for (int k = 0; k < 16; k++) begin
            w[k] = (base >= 0) ? W'(base + k) : W'($urandom);
            push(w[k]);
        end
        @(negedge clk);
        p0        = pops;
        dn0       = dones;
        slot      = s[2:0];
        degree    = d[4:0];
        start_sto = 1'b1;
        m_valid[s] = 1'b0;
        lat = 0;
        ok  = 1'b0;
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            start_sto = 1'b0;
            if (done_sto) begin
                lat = k;
                ok  = 1'b1;
                break;
            end
        end
        chk("store_done_seen", ok, 1);
        npop = pops - p0;
        if (ok) begin
            for (int k = 0; k <= n; k++) begin
                m_coef[s][k]  = w[k];
                m_known[s][k] = 1'b1;
            end
            m_deg[s]   = n;
            m_valid[s] = 1'b1;
        end
        @(negedge clk);
        chk("done_pulse_width", done_sto, 0);
        chk("done_once", dones - dn0, 1);
        wptr = rptr;
    endtask

    initial begin
        int lat;
        int np;
        int p0;
        int dn0;
        int s;
        int d;
        logic [W-1:0] w0;

        tbl[0] = '{2, 3, 3, 10};
        tbl[1] = '{0, 0, 0, 4};
        tbl[2] = '{5, 10, 10, 24};
        tbl[3] = '{7, 15, 10, 24};
        tbl[4] = '{3, 11, 10, 24};
        tbl[5] = '{1, 7, 7, 18};
        tbl[6] = '{6, 31, 10, 24};

        model_reset();
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done_sto, 0);
        @(negedge clk);
        rst = 1'b1;
        check_slots();

        // Vector table: slot, degree, expected clamp and latency
        for (int t = 0; t < 7; t++) begin
            store(tbl[t].s, tbl[t].d, (t == 0) ? 5 : -1, lat, np);
            chk($sformatf("tbl%0d_lat", t), lat, tbl[t].exp_lat);
            chk($sformatf("tbl%0d_pops", t), np, tbl[t].exp_n + 1);
            rd_slot = tbl[t].s[2:0];
            rd_idx  = 4'd12;
            #1;
            chk($sformatf("tbl%0d_deg", t), rd_degree, tbl[t].exp_n);
            chk($sformatf("tbl%0d_valid", t), rd_valid, 1);
            chk($sformatf("tbl%0d_idx12", t), rd_coef, 0);
        end
        rd_slot = 3'd2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rd_idx = i[3:0];
            #1;
            chk("slot2_fixed_coef", rd_coef, 5 + i);
        end
        check_slots();

        // FIFO empty for 5 cycles before every word
        gap_mode = 1'b1;
        store(0, 1, -1, lat, np);
        gap_mode = 1'b0;
        chk("gap_pops", np, 2);
        chk("gap_no_empty_pop", bad_pops, 0);
        chk("gap_stalled", (lat > 6) ? 1 : 0, 1);
        check_slots();

        // Abort in CAPT of the second word
        w0 = W'($urandom);
        push(w0);
        for (int k = 1; k < 16; k++) push(W'($urandom));
        @(negedge clk);
        p0 = pops;
        dn0 = dones;
        slot = 3'd1;
        degree = 5'd4;
        start_sto = 1'b1;
        repeat (4) begin
            @(negedge clk);
            start_sto = 1'b0;
        end
        chk("abort_pops_before", pops - p0, 2);
        clear_all = 1'b1;
        @(negedge clk);
        clear_all = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_pops_after", pops - p0, 2);
        chk("abort_no_done", dones - dn0, 0);
        chk("abort_busy", busy, 0);
        model_clear();
        m_coef[1][0]  = w0;
        m_known[1][1] = 1'b0;
        wptr = rptr;
        check_slots();

        // Start and clear in the same cycle
        for (int k = 0; k < 16; k++) push(W'($urandom));
        @(negedge clk);
        p0 = pops;
        dn0 = dones;
        slot = 3'd3;
        degree = 5'd2;
        start_sto = 1'b1;
        clear_all = 1'b1;
        @(negedge clk);
        start_sto = 1'b0;
        clear_all = 1'b0;
        chk("startclr_busy", busy, 0);
        repeat (10) @(negedge clk);
        chk("startclr_pops", pops - p0, 0);
        chk("startclr_done", dones - dn0, 0);
        wptr = rptr;

        // Random stores
        for (int r = 0; r < 24; r++) begin
            s = $urandom_range(7);
            d = $urandom_range(31);
            store(s, d, -1, lat, np);
            chk("rnd_lat", lat, 2 * (((d > 10) ? 10 : d) + 1) + 2);
            chk("rnd_pops", np, ((d > 10) ? 10 : d) + 1);
            if (r % 8 == 7) check_slots();
        end

        // Reset during READ
        for (int k = 0; k < 16; k++) push(W'($urandom));
        @(negedge clk);
        slot = 3'd4;
        degree = 5'd5;
        start_sto = 1'b1;
        @(negedge clk);
        start_sto = 1'b0;
        chk("pre_rst_rd_en", fifo_rd_en, 1);
        rst = 1'b0;
        rd_slot = 3'd4;
        #1;
        chk("mid_rst_rd_en", fifo_rd_en, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", rd_valid, 0);
        @(negedge clk);
        rst = 1'b1;
        wptr = rptr;
        model_reset();
        check_slots();

`ifdef POLY_STORE_COUNT_EN
        chk("cnt_after_rst", sto_count, 0);
        for (int k = 0; k < 3; k++) store(k, k + 1, -1, lat, np);
        chk("cnt_three", sto_count, 3);
        @(negedge clk);
        clear_all = 1'b1;
        @(negedge clk);
        clear_all = 1'b0;
        chk("cnt_cleared", sto_count, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
